pio_poll_master: RTL and testbench

- Avalon-MM read initiator that periodically polls a 16-bit input-PIO slave.
- The slave returns registered readdata one or more cycles after the address is presented.
- Captures each sample, flags changes between successive samples, and keeps a saturating change counter.
- Sits in the lab system between a PIO-style status slave and logic or software that needs a timestamp-free record of input activity.

---
 rtl/pio_poll_master.sv | 167 ++++++++++++++++
 tb/tb_pio_poll_master.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pio_poll_master.sv
// pio_poll_master -- Avalon-MM read initiator that periodically polls a
// PIO-style input slave, records each sample and counts changes between
// successive samples.
//
// Optional build macro: POLL_CHANGE_IRQ_EN adds a sticky change interrupt
// (irq output, irq_ack input). Without it the port list has no irq pins.
//
// Ports:
//   clk           system clock, rising edge
//   reset_n       asynchronous active-low reset
//   enable        polling enable (level)
//   clear_count   synchronous clear of change_count (wins over increment)
//   address       slave address; POLL_ADDR while read=1, else 0
//   read          one-cycle read strobe
//   readdata      registered slave read data
//   sample        last captured readdata
//   sample_valid  one-cycle pulse when sample updates
//   changed       one-cycle pulse with sample_valid when the value differs
//   change_count  saturating change counter
//   busy          high from read issue through capture
//   irq, irq_ack  (POLL_CHANGE_IRQ_EN only) sticky change flag and its ack
module pio_poll_master #(
  parameter int DATA_W       = 16,
  parameter int ADDR_W       = 2,
  parameter int POLL_ADDR    = 0,
  parameter int POLL_DIV     = 16,
  parameter int READ_LATENCY = 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              enable,
  input  logic              clear_count,
  output logic [ADDR_W-1:0] address,
  output logic              read,
  input  logic [DATA_W-1:0] readdata,
  output logic [DATA_W-1:0] sample,
  output logic              sample_valid,
  output logic              changed,
  output logic [DATA_W-1:0] change_count,
  output logic              busy
`ifdef POLL_CHANGE_IRQ_EN
  ,
  output logic              irq,
  input  logic              irq_ack
`endif
);

  localparam int DIV_W  = (POLL_DIV > 1) ? $clog2(POLL_DIV) : 1;
  localparam int WAIT_W = 3;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_CAPTURE
  } state_t;

  state_t              state, state_nxt;
  logic [DIV_W-1:0]    div_cnt;
  logic [WAIT_W-1:0]   wait_cnt;
  logic                tick;
  logic                first_done;
  logic                capture;
  logic                chg_now;

  // Poll divider: free-runs while enabled, parked at 0 otherwise.
  assign tick = enable && (div_cnt == DIV_W'(POLL_DIV - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div_cnt <= '0;
    end else if (!enable || tick) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + DIV_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Counts WAIT cycles; WAIT lasts READ_LATENCY-1 cycles.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wait_cnt <= '0;
    end else if (state == S_WAIT) begin
      wait_cnt <= wait_cnt + WAIT_W'(1);
    end else begin
      wait_cnt <= '0;
    end
  end

  // Ticks outside IDLE are dropped, never queued.
  always_comb begin
    state_nxt = state;
    read      = 1'b0;
    busy      = 1'b0;
    address   = '0;
    case (state)
      S_IDLE: begin
        if (tick) state_nxt = S_ISSUE;
      end
      S_ISSUE: begin
        read      = 1'b1;
        busy      = 1'b1;
        address   = ADDR_W'(POLL_ADDR);
        state_nxt = (READ_LATENCY == 1) ? S_CAPTURE : S_WAIT;
      end
      S_WAIT: begin
        busy = 1'b1;
        if (wait_cnt == WAIT_W'(READ_LATENCY - 2)) state_nxt = S_CAPTURE;
      end
      S_CAPTURE: begin
        busy      = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  assign capture = (state == S_CAPTURE);
  // The very first capture after reset has no predecessor to compare with.
  assign chg_now = capture && first_done && (readdata != sample);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sample       <= '0;
      sample_valid <= 1'b0;
      changed      <= 1'b0;
      first_done   <= 1'b0;
      change_count <= '0;
    end else begin
      sample_valid <= 1'b0;
      changed      <= 1'b0;
      if (capture) begin
        sample       <= readdata;
        sample_valid <= 1'b1;
        changed      <= chg_now;
        first_done   <= 1'b1;
      end
      if (clear_count) begin
        change_count <= '0;
      end else if (chg_now && (change_count != '1)) begin
        change_count <= change_count + DATA_W'(1);
      end
    end
  end

`ifdef POLL_CHANGE_IRQ_EN
  // Set dominates acknowledge when both occur in the same cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      irq <= 1'b0;
    end else if (changed) begin
      irq <= 1'b1;
    end else if (irq_ack) begin
      irq <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_pio_poll_master.sv
// Testbench for pio_poll_master: two instances (A: 16-bit, POLL_DIV=16,
// READ_LATENCY=1; B: 4-bit, POLL_DIV=5, READ_LATENCY=3, POLL_ADDR=2)
// checked every cycle against a timeline model plus directed checks.
module tb_pio_poll_master;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n [2];
  logic        en    [2];
  logic        clr   [2];
  logic [15:0] rdv   [2];

  logic [15:0] o_sample [2];
  logic [15:0] o_cnt    [2];
  logic [1:0]  o_addr   [2];
  logic        o_read   [2];
  logic        o_sv     [2];
  logic        o_chg    [2];
  logic        o_busy   [2];

  logic [3:0] smp_b, cnt_b;

  pio_poll_master #(
    .DATA_W(16), .ADDR_W(2), .POLL_ADDR(0), .POLL_DIV(16), .READ_LATENCY(1)
  ) u_dut_a (
    .clk(clk), .reset_n(rst_n[0]), .enable(en[0]), .clear_count(clr[0]),
    .address(o_addr[0]), .read(o_read[0]), .readdata(rdv[0]),
    .sample(o_sample[0]), .sample_valid(o_sv[0]), .changed(o_chg[0]),
    .change_count(o_cnt[0]), .busy(o_busy[0])
  );

  pio_poll_master #(
    .DATA_W(4), .ADDR_W(2), .POLL_ADDR(2), .POLL_DIV(5), .READ_LATENCY(3)
  ) u_dut_b (
    .clk(clk), .reset_n(rst_n[1]), .enable(en[1]), .clear_count(clr[1]),
    .address(o_addr[1]), .read(o_read[1]), .readdata(rdv[1][3:0]),
    .sample(smp_b), .sample_valid(o_sv[1]), .changed(o_chg[1]),
    .change_count(cnt_b), .busy(o_busy[1])
  );

  assign o_sample[1] = {12'd0, smp_b};
  assign o_cnt[1]    = {12'd0, cnt_b};

  // Instance configuration as seen by the model
  int          P    [2] = '{16, 5};
  int          L    [2] = '{1, 3};
  logic [15:0] MASK [2] = '{16'hFFFF, 16'h000F};
  logic [1:0]  PA   [2] = '{2'd0, 2'd2};
  string       NM   [2] = '{"A", "B"};

  // Model: age = consecutive enabled edges, trd = cycle of pending read (-1 none)
  int          cyc;
  int          age  [2];
  int          trd  [2];
  logic [15:0] ms   [2];
  logic [15:0] mc   [2];
  bit          msv  [2];
  bit          mchg [2];
  bit          mfd  [2];

  int read_seen [2];
  int sv_seen   [2];
  int chg_seen  [2];

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  function automatic bit m_busy(input int i);
    return (trd[i] >= 0) && (cyc >= trd[i]) && (cyc <= trd[i] + L[i]);
  endfunction

  task automatic m_reset(input int i);
    age[i] = 0; trd[i] = -1; ms[i] = '0; mc[i] = '0;
    msv[i] = 0; mchg[i] = 0; mfd[i] = 0;
  endtask

  // Apply one rising edge to the model using the inputs of cycle cyc.
  task automatic m_edge(input int i);
    bit          idle;
    logic [15:0] d;
    if (!rst_n[i]) begin
      m_reset(i);
      return;
    end
    idle    = !m_busy(i);
    msv[i]  = 0;
    mchg[i] = 0;
    if (trd[i] >= 0 && cyc == trd[i] + L[i]) begin
      d       = rdv[i] & MASK[i];
      mchg[i] = mfd[i] && (d != ms[i]);
      ms[i]   = d;
      mfd[i]  = 1;
      msv[i]  = 1;
      if (mchg[i] && mc[i] != MASK[i]) mc[i] = mc[i] + 16'd1;
      trd[i]  = -1;
    end
    if (clr[i]) mc[i] = '0;
    if (en[i] && idle && (age[i] % P[i] == P[i] - 1)) trd[i] = cyc + 1;
    age[i] = en[i] ? age[i] + 1 : 0;
  endtask

  task automatic check_all();
    for (int i = 0; i < 2; i++) begin
      bit r;
      r = (trd[i] == cyc);
      chk({NM[i], ".read"},   32'(o_read[i]),   32'(r));
      chk({NM[i], ".addr"},   32'(o_addr[i]),   32'(r ? PA[i] : 2'd0));
      chk({NM[i], ".busy"},   32'(o_busy[i]),   32'(m_busy(i)));
      chk({NM[i], ".sv"},     32'(o_sv[i]),     32'(msv[i]));
      chk({NM[i], ".chg"},    32'(o_chg[i]),    32'(mchg[i]));
      chk({NM[i], ".sample"}, 32'(o_sample[i]), 32'(ms[i]));
      chk({NM[i], ".count"},  32'(o_cnt[i]),    32'(mc[i]));
      read_seen[i] += int'(o_read[i]);
      sv_seen[i]   += int'(o_sv[i]);
      chg_seen[i]  += int'(o_chg[i]);
    end
  endtask

  // Check the current cycle, advance one clock, return at the falling edge.
  task automatic cycle();
    check_all();
    @(posedge clk);
    m_edge(0);
    m_edge(1);
    cyc++;
    @(negedge clk);
  endtask

  task automatic clear_seen(input int i);
    read_seen[i] = 0; sv_seen[i] = 0; chg_seen[i] = 0;
  endtask

  task automatic reset_pulse(input int i);
    rst_n[i] = 1'b0;
    #1;
    m_reset(i);
    chk({NM[i], ".rst_read"},   32'(o_read[i]),   32'd0);
    chk({NM[i], ".rst_addr"},   32'(o_addr[i]),   32'd0);
    chk({NM[i], ".rst_busy"},   32'(o_busy[i]),   32'd0);
    chk({NM[i], ".rst_sv"},     32'(o_sv[i]),     32'd0);
    chk({NM[i], ".rst_chg"},    32'(o_chg[i]),    32'd0);
    chk({NM[i], ".rst_sample"}, 32'(o_sample[i]), 32'd0);
    chk({NM[i], ".rst_count"},  32'(o_cnt[i]),    32'd0);
    cycle();
    rst_n[i] = 1'b1;
  endtask

  task automatic wait_read(input int i, input string tag);
    int n;
    n = 0;
    while (!o_read[i] && n < 40) begin
      cycle();
      n++;
    end
    chk(tag, 32'(o_read[i]), 32'd1);
  endtask

  logic [15:0] seq [4] = '{16'h0001, 16'h0002, 16'h0002, 16'h0003};

  initial begin
    int c0, n;
    for (int i = 0; i < 2; i++) begin
      rst_n[i] = 1'b0; en[i] = 1'b0; clr[i] = 1'b0; rdv[i] = '0;
      m_reset(i);
      clear_seen(i);
    end
    cyc = 0;
    @(negedge clk);
    @(negedge clk);
    check_all();
    rst_n[0] = 1'b1;
    rst_n[1] = 1'b1;

    // First poll latency on A, then a constant 0x00A5 over three polls
    en[0]  = 1'b1;
    rdv[0] = 16'h00A5;
    for (int k = 1; k <= 19; k++) begin
      if (k == 16) chk("A.read_c16", 32'(o_read[0]), 32'd0);
      if (k == 17) chk("A.read_c17", 32'(o_read[0]), 32'd1);
      if (k == 19) chk("A.sv_c19", 32'(o_sv[0]), 32'd1);
      if (k == 19) chk("A.sample_c19", 32'(o_sample[0]), 32'h00A5);
      cycle();
    end
    repeat (48) cycle();
    chk("A.const_sample", 32'(o_sample[0]), 32'h00A5);
    chk("A.const_chg", 32'(chg_seen[0]), 32'd0);
    chk("A.const_count", 32'(o_cnt[0]), 32'd0);

    // Fresh start, then 1 -> 2 -> 2 -> 3 over four polls
    reset_pulse(0);
    clear_seen(0);
    rdv[0] = seq[0];
    repeat (2) cycle();
    for (int v = 0; v < 4; v++) begin
      rdv[0] = seq[v];
      repeat (16) cycle();
    end
    repeat (2) cycle();
    chk("A.seq_sv", 32'(sv_seen[0]), 32'd4);
    chk("A.seq_chg", 32'(chg_seen[0]), 32'd2);
    chk("A.seq_count", 32'(o_cnt[0]), 32'd2);

    // Random traffic on both; B always presents a value different from its sample
    en[1] = 1'b1;
    for (int k = 0; k < 400; k++) begin
      rdv[0] = 16'($urandom);
      clr[0] = ($urandom % 20 == 0);
      rdv[1] = (ms[1] + 16'd1 + 16'($urandom % 15)) & 16'h000F;
      cycle();
    end
    clr[0] = 1'b0;
    chk("B.saturated", 32'(o_cnt[1]), 32'h0000000F);
    for (int k = 0; k < 12; k++) begin
      rdv[1] = (ms[1] + 16'd1 + 16'($urandom % 15)) & 16'h000F;
      cycle();
    end
    chk("B.sat_hold", 32'(o_cnt[1]), 32'h0000000F);

    // Clear coincident with a change on B
    n = 0;
    while (!(trd[1] >= 0 && cyc == trd[1] + L[1]) && n < 40) begin
      cycle();
      n++;
    end
    chk("B.capture_found", 32'(n < 40), 32'd1);
    rdv[1] = (~ms[1]) & 16'h000F;
    clr[1] = 1'b1;
    cycle();
    clr[1] = 1'b0;
    chk("B.clr_chg", 32'(o_chg[1]), 32'd1);
    chk("B.clr_count", 32'(o_cnt[1]), 32'd0);

    // Read-to-sample_valid distance with READ_LATENCY=3
    rdv[1] = 16'h000A;
    wait_read(1, "B.lat_read");
    c0 = cyc;
    n = 0;
    while (!o_sv[1] && n < 20) begin
      cycle();
      n++;
    end
    chk("B.lat_dist", 32'(cyc - c0), 32'd4);
    chk("B.lat_sample", 32'(o_sample[1]), 32'h0000000A);

    // Drop enable in WAIT: capture still happens, no more reads
    wait_read(1, "B.drop_read");
    cycle();
    chk("B.drop_in_wait", 32'(o_busy[1] && !o_read[1]), 32'd1);
    en[1]  = 1'b0;
    rdv[1] = 16'h0003;
    clear_seen(1);
    repeat (30) cycle();
    chk("B.drop_sv", 32'(sv_seen[1]), 32'd1);
    chk("B.drop_reads", 32'(read_seen[1]), 32'd0);
    chk("B.drop_sample", 32'(o_sample[1]), 32'h00000003);

    // Reset during WAIT, then first poll after release never flags a change
    en[1] = 1'b1;
    wait_read(1, "B.rst_read");
    cycle();
    reset_pulse(1);
    rdv[1] = 16'h0005;
    clear_seen(1);
    n = 0;
    while (!o_sv[1] && n < 40) begin
      cycle();
      n++;
    end
    chk("B.post_rst_sv", 32'(o_sv[1]), 32'd1);
    chk("B.post_rst_chg", 32'(o_chg[1]), 32'd0);
    chk("B.post_rst_sample", 32'(o_sample[1]), 32'h00000005);
    repeat (5) cycle();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
